// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encodings and widths for the shift-register family
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Default frame width, shared with the downstream SIPO register.
  localparam int SR_WIDTH = 3;
  localparam int GAP_CW   = 4;

endpackage

// File: rtl/sr_down_counter.sv
// rtl/sr_down_counter.sv - loadable down counter that saturates at zero
module sr_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_frame_serializer.sv
// rtl/piso_frame_serializer.sv - parallel-in/serial-out frame transmitter
// Drives the SIPO serial input with framed bits, valid and last-bit markers.
module piso_frame_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH      = SR_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]     BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CW'(GAP_CYCLES - 1) : '0;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic [CW-1:0]     bit_count;
  logic              bit_zero;
  logic [GAP_CW-1:0] gap_count;
  logic              gap_zero;
  logic              xfer;
  logic              last_bit;

  assign last_bit  = (state == ST_SHIFT) && bit_zero;
  assign din_ready = !clear && ((state == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)));
  assign xfer      = din_valid && din_ready;

  sr_down_counter #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     (xfer),
    .load_val (BIT_LOAD),
    .dec      ((state == ST_SHIFT) && !bit_zero),
    .count    (bit_count),
    .zero     (bit_zero)
  );

  sr_down_counter #(.W(GAP_CW)) u_gap_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     (last_bit && (GAP_CYCLES != 0)),
    .load_val (GAP_LOAD),
    .dec      (state == ST_GAP),
    .count    (gap_count),
    .zero     (gap_zero)
  );

  // Outputs are computed for the cycle that follows each edge, so they stay registered.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_IDLE;
      sr         <= '0;
      so         <= 1'b0;
      so_valid   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (xfer) begin
            state    <= ST_SHIFT;
            sr       <= din;
            so       <= head_bit(din);
            so_valid <= 1'b1;
            busy     <= 1'b1;
          end else begin
            so       <= 1'b0;
            so_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!bit_zero) begin
            sr         <= shifted(sr);
            so         <= head_bit(shifted(sr));
            so_valid   <= 1'b1;
            frame_done <= (bit_count == CW'(1));
            busy       <= 1'b1;
          end else if (GAP_CYCLES != 0) begin
            state      <= ST_GAP;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
          end else if (xfer) begin
            sr         <= din;
            so         <= head_bit(din);
            so_valid   <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b1;
          end else begin
            state      <= ST_IDLE;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_GAP: begin
          so         <= 1'b0;
          so_valid   <= 1'b0;
          frame_done <= 1'b0;
          busy       <= (gap_count != '0);
          if (gap_zero) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          so         <= 1'b0;
          so_valid   <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// tb/tb_piso_frame_serializer.sv - directed self-checking bench for piso_frame_serializer
module tb_piso_frame_serializer;
  import shift_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear;
  logic [2:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, so_a, sov_a, fd_a, busy_a;
  logic       ready_b, so_b, sov_b, fd_b, busy_b;
  logic [2:0] sipo;
  int         n_checks = 0;
  int         n_fail   = 0;

  piso_frame_serializer #(.WIDTH(SR_WIDTH), .MSB_FIRST(1), .GAP_CYCLES(0)) u_a (
    .clk(clk), .clear(clear), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .so(so_a), .so_valid(sov_a), .frame_done(fd_a), .busy(busy_a)
  );

  piso_frame_serializer #(.WIDTH(SR_WIDTH), .MSB_FIRST(0), .GAP_CYCLES(2)) u_b (
    .clk(clk), .clear(clear), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .so(so_b), .so_valid(sov_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Reference 3-bit SIPO fed by the serializer under test.
  always_ff @(posedge clk) begin
    if (clear) sipo <= '0;
    else       sipo <= {sipo[1:0], so_a};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; valid_a = 1'b0; valid_b = 1'b0; din_a = '0; din_b = '0;
    tick(); tick();
    n_checks++;
    if ({so_a, sov_a, fd_a, busy_a, ready_a} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_a got=%b want=00000", {so_a, sov_a, fd_a, busy_a, ready_a});
    end
    n_checks++;
    if ({so_b, sov_b, fd_b, busy_b, ready_b} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_b got=%b want=00000", {so_b, sov_b, fd_b, busy_b, ready_b});
    end
    clear = 1'b0; #1;
    n_checks++;
    if ({ready_a, ready_b} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset got=%b want=11", {ready_a, ready_b});
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_s [4] = '{5'b11010, 5'b01010, 5'b11111, 5'b00001};
    din_a = 3'b101; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({so_a, sov_a, fd_a, busy_a, ready_a} !== exp_s[c]) begin
        n_fail++; $display("FAIL single c%0d got=%b want=%b", c + 1, {so_a, sov_a, fd_a, busy_a, ready_a}, exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_s [7] = '{5'b11010, 5'b11010, 5'b01111, 5'b01010, 5'b11010, 5'b11111, 5'b00001};
    din_a = 3'b110; valid_a = 1'b1;
    tick();
    din_a = 3'b011;
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if ({so_a, sov_a, fd_a, busy_a, ready_a} !== exp_s[c]) begin
        n_fail++; $display("FAIL b2b c%0d got=%b want=%b", c + 1, {so_a, sov_a, fd_a, busy_a, ready_a}, exp_s[c]);
      end
      tick();
      if (c == 2) valid_a = 1'b0;
    end
  endtask

  task automatic test_gap_lsb();
    logic [4:0] exp_s [12] = '{5'b11010, 5'b01010, 5'b01110, 5'b00010, 5'b00010, 5'b00001,
                               5'b01010, 5'b01010, 5'b11110, 5'b00010, 5'b00010, 5'b00001};
    din_b = 3'b001; valid_b = 1'b1;
    tick();
    din_b = 3'b100;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if ({so_b, sov_b, fd_b, busy_b, ready_b} !== exp_s[c]) begin
        n_fail++; $display("FAIL gap c%0d got=%b want=%b", c + 1, {so_b, sov_b, fd_b, busy_b, ready_b}, exp_s[c]);
      end
      tick();
      if (c == 5) valid_b = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] exp_s [4] = '{5'b01010, 5'b11010, 5'b01111, 5'b00001};
    din_a = 3'b111; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    n_checks++;
    if ({so_a, sov_a, fd_a, busy_a} !== 4'b1101) begin
      n_fail++; $display("FAIL mid_second_bit got=%b want=1101", {so_a, sov_a, fd_a, busy_a});
    end
    clear = 1'b1; #1;
    n_checks++;
    if (ready_a !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready_in_clear got=%b want=0", ready_a);
    end
    tick();
    n_checks++;
    if ({so_a, sov_a, fd_a, busy_a} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_abort got=%b want=0000", {so_a, sov_a, fd_a, busy_a});
    end
    clear = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({so_a, sov_a, fd_a, busy_a, ready_a} !== 5'b00001) begin
        n_fail++; $display("FAIL mid_idle c%0d got=%b want=00001", c, {so_a, sov_a, fd_a, busy_a, ready_a});
      end
      tick();
    end
    din_a = 3'b010; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({so_a, sov_a, fd_a, busy_a, ready_a} !== exp_s[c]) begin
        n_fail++; $display("FAIL mid_next c%0d got=%b want=%b", c + 1, {so_a, sov_a, fd_a, busy_a, ready_a}, exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [2:0] words [3] = '{3'b101, 3'b010, 3'b111};
    int guard;
    for (int w = 0; w < 3; w++) begin
      din_a = words[w]; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      guard = 0;
      while (!fd_a && guard < 10) begin
        tick();
        guard++;
      end
      n_checks++;
      if (fd_a !== 1'b1) begin
        n_fail++; $display("FAIL loop_frame_done_timeout w%0d got=%b want=1", w, fd_a);
      end
      tick();
      n_checks++;
      if (sipo !== words[w]) begin
        n_fail++; $display("FAIL loop_sipo w%0d got=%b want=%b", w, sipo, words[w]);
      end
    end
    din_a = 3'b101; valid_a = 1'b1;
    tick();
    din_a = 3'b010;
    n_checks++;
    if ({busy_a, ready_a} !== 2'b10) begin
      n_fail++; $display("FAIL busy_pulse_ready got=%b want=10", {busy_a, ready_a});
    end
    tick();
    valid_a = 1'b0;
    tick(); tick();
    n_checks++;
    if ({sipo, sov_a, busy_a} !== 5'b10100) begin
      n_fail++; $display("FAIL busy_pulse_after got=%b want=10100", {sipo, sov_a, busy_a});
    end
    tick();
    n_checks++;
    if ({sov_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL busy_pulse_no_xfer got=%b want=00", {sov_a, busy_a});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_lsb();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
